// File: rtl/uart_rx_mc.sv
// UART receiver: 3-sample majority vote, runtime baud divisor, optional parity, 1-2 stop bits, per-frame error flags, FWFT frame FIFO.
// Latency: frame written to the FIFO the cycle after the final stop-bit vote; rx_valid rises one cycle later.
// Backpressure: rx_ready pops the head; a frame arriving on a full FIFO without a same-cycle pop is dropped and pulses rx_overrun.
// Optional simulation-only console print of received characters: define UART_RX_MC_PRINT_EN.
module uart_rx_mc #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx_en,
    input  logic                          rxd,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_break,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    typedef struct packed {
        logic                 brk;
        logic                 ferr;
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } ent_t;

    logic                 rxd_m, rxd_s, rxd_d;
    state_t               state;
    logic [DIV_W-1:0]     div_q, presc;
    logic [SW-1:0]        scnt;
    logic [3:0]           bcnt;
    logic                 smp0, smp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr, par_bit, stop_or;
    logic                 push_vld;
    ent_t                 push_ent;

    ent_t                 mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    logic fall, tick, at_s0, at_s1, at_vote, bit_end, vote;
    logic pop, full, wr;

    // Two-flop synchroniser plus one delay stage for edge detection; frozen while disabled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else if (rx_en) begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign fall    = rxd_d & ~rxd_s;
    assign tick    = (state != S_IDLE) && (presc == '0);
    assign at_s0   = tick && (scnt == SW'(OVERSAMPLE/2 - 1));
    assign at_s1   = tick && (scnt == SW'(OVERSAMPLE/2));
    assign at_vote = tick && (scnt == SW'(OVERSAMPLE/2 + 1));
    assign bit_end = tick && (scnt == SW'(OVERSAMPLE - 1));
    // third sample is taken live on the vote tick
    assign vote    = (smp0 & smp1) | (smp0 & rxd_s) | (smp1 & rxd_s);

    // Frame FSM with prescaler, sample counter and frame assembly
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            div_q    <= '0;
            presc    <= '0;
            scnt     <= '0;
            bcnt     <= '0;
            smp0     <= 1'b0;
            smp1     <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            par_bit  <= 1'b0;
            stop_or  <= 1'b0;
            push_vld <= 1'b0;
            push_ent <= '0;
        end else begin
            push_vld <= 1'b0;
            if (!rx_en) begin
                state <= S_IDLE;
            end else begin
                if (state != S_IDLE) begin
                    presc <= (presc == '0) ? div_q : presc - DIV_W'(1);
                    if (tick) scnt <= (scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + SW'(1);
                    if (at_s0) smp0 <= rxd_s;
                    if (at_s1) smp1 <= rxd_s;
                end
                case (state)
                    S_IDLE: begin
                        if (fall) begin
                            state   <= S_START;
                            div_q   <= baud_div;
                            presc   <= '0;
                            scnt    <= '0;
                            bcnt    <= '0;
                            perr    <= 1'b0;
                            ferr    <= 1'b0;
                            par_bit <= 1'b0;
                            stop_or <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (at_vote && vote) state <= S_IDLE;
                        else if (bit_end)    state <= S_DATA;
                    end
                    S_DATA: begin
                        if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (bit_end) begin
                            if (bcnt == 4'(DATA_BITS - 1)) begin
                                bcnt  <= '0;
                                state <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bcnt <= bcnt + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (at_vote) begin
                            par_bit <= vote;
                            // odd wants XOR(data,parity)=1, even wants 0
                            perr    <= (^shreg) ^ vote ^ (PARITY == 1);
                        end
                        if (bit_end) state <= S_STOP;
                    end
                    S_STOP: begin
                        if (at_vote) begin
                            if (bcnt == 4'(STOP_BITS - 1)) begin
                                // leave on the final vote so the next start edge can be caught half a bit early
                                push_vld      <= 1'b1;
                                push_ent.data <= shreg;
                                push_ent.perr <= perr;
                                push_ent.ferr <= ferr | ~vote;
                                push_ent.brk  <= (shreg == '0) & ~par_bit & ~stop_or & ~vote;
                                state         <= S_IDLE;
                            end else begin
                                ferr    <= ferr | ~vote;
                                stop_or <= stop_or | vote;
                            end
                        end
                        if (bit_end) bcnt <= bcnt + 4'd1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign pop  = rx_valid & rx_ready;
    assign full = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign wr   = push_vld & (~full | pop);

    // Frame FIFO; a same-cycle pop frees the slot a full-FIFO push needs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= push_vld & full & ~pop;
            if (wr) begin
                mem[wr_ptr] <= push_ent;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !wr) fifo_level <= fifo_level - 1'b1;
        end
    end

    assign rx_valid = (fifo_level != '0);
    assign rx_data  = mem[rd_ptr].data;
    assign rx_perr  = mem[rd_ptr].perr;
    assign rx_ferr  = mem[rd_ptr].ferr;
    assign rx_break = mem[rd_ptr].brk;

`ifdef UART_RX_MC_PRINT_EN
    string line_buf = "";

    // Line-buffered console echo of every frame written into the FIFO
    always @(negedge clk) begin
        if (resetn && wr) begin
            if (push_ent.brk)
                line_buf = {line_buf, "<BRK>"};
            else if (push_ent.ferr)
                line_buf = {line_buf, "<FERR>"};
            else if (8'(push_ent.data) == 8'd10 || 8'(push_ent.data) == 8'd13) begin
                $write("%s\n", line_buf);
                line_buf = "";
            end else
                line_buf = {line_buf, $sformatf("%c", 8'(push_ent.data))};
            if (line_buf.len() >= 256) begin
                $write("%s\n", line_buf);
                line_buf = "";
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_mc.sv
module tb_uart_rx_mc;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_en = 1'b1;
    logic       rxd = 1'b1;
    logic [15:0] baud_div = '0;
    logic       rx_valid, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_perr, rx_ferr, rx_break, rx_overrun;
    logic [2:0] fifo_level;

    logic       p_en = 1'b0;
    logic       p_valid, p_ready = 1'b0;
    logic [7:0] p_data;
    logic       p_perr, p_ferr, p_break, p_overrun;
    logic [2:0] p_level;

    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;
    int pop_cnt = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] d;
        int         div;
        bit         glitch;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_rx_mc #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .resetn(resetn), .rx_en(rx_en), .rxd(rxd), .baud_div(baud_div),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_perr(rx_perr),
        .rx_ferr(rx_ferr), .rx_break(rx_break), .rx_overrun(rx_overrun), .fifo_level(fifo_level)
    );

    uart_rx_mc #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(4)) u_par (
        .clk(clk), .resetn(resetn), .rx_en(p_en), .rxd(rxd), .baud_div(baud_div),
        .rx_valid(p_valid), .rx_ready(p_ready), .rx_data(p_data), .rx_perr(p_perr),
        .rx_ferr(p_ferr), .rx_break(p_break), .rx_overrun(p_overrun), .fifo_level(p_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every popped head against the oldest expected frame
    always @(negedge clk) begin
        if (resetn && rx_overrun) ovr_cnt++;
        if (resetn && rx_valid && rx_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got data %0h, none expected", rx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_data",  {24'h0, rx_data}, {24'h0, e.d});
                check("pop_perr",  {31'h0, rx_perr},  {31'h0, e.perr});
                check("pop_ferr",  {31'h0, rx_ferr},  {31'h0, e.ferr});
                check("pop_break", {31'h0, rx_break}, {31'h0, e.brk});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rxd = 1'b1;
        end
    endtask

    // par < 0: no parity bit; drop_bit >= 0: rx_en falls mid-way through that bit
    task automatic send_frame(input logic [7:0] d, input int div, input bit glitch,
                              input int par, input int drop_bit);
        logic v;
        int   nb, len;
        len = 16 * (div + 1);
        nb  = (par < 0) ? 10 : 11;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                     v = 1'b0;
            else if (b <= 8)                v = d[b-1];
            else if (b == 9 && par >= 0)    v = par[0];
            else                            v = 1'b1;
            for (int c = 0; c < len; c++) begin
                @(posedge clk); #1;
                rxd = (glitch && b >= 1 && b <= 8 && c == 7 * (div + 1) + 1) ? ~v : v;
                if (b == drop_bit && c == 5) rx_en = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_level != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{d: 8'h55, div: 0, glitch: 1'b0, exp_d: 8'h55};
        vecs[1] = '{d: 8'hA3, div: 0, glitch: 1'b0, exp_d: 8'hA3};
        vecs[2] = '{d: 8'h3C, div: 0, glitch: 1'b1, exp_d: 8'h3C};
        vecs[3] = '{d: 8'hFF, div: 1, glitch: 1'b0, exp_d: 8'hFF};
        vecs[4] = '{d: 8'h00, div: 2, glitch: 1'b0, exp_d: 8'h00};
        vecs[5] = '{d: 8'h81, div: 0, glitch: 1'b1, exp_d: 8'h81};

        // reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   {31'h0, rx_valid},   0);
        check("rst_level",   {29'h0, fifo_level}, 0);
        check("rst_data",    {24'h0, rx_data},    0);
        check("rst_flags",   {29'h0, rx_perr, rx_ferr, rx_break}, 0);
        check("rst_overrun", {31'h0, rx_overrun}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(20);

        // table-driven frames, consumer always ready
        rx_ready = 1'b1;
        foreach (vecs[i]) begin
            baud_div = 16'(vecs[i].div);
            exp_q.push_back('{d: vecs[i].exp_d, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
            send_frame(vecs[i].d, vecs[i].div, vecs[i].glitch, -1, -1);
            idle(32);
        end
        wait_drain("table_drain");
        baud_div = '0;

        // 4-clk low pulse on an idle line is a false start
        begin
            int pc;
            pc = pop_cnt;
            @(posedge clk); #1; rxd = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            rxd = 1'b1;
            idle(64);
            check("false_start_level", {29'h0, fifo_level}, 0);
            check("false_start_pops",  pop_cnt, pc);
        end

        // even parity with wrong parity bit, seen only by the parity receiver
        rx_en = 1'b0;
        p_en  = 1'b1;
        idle(8);
        send_frame(8'h07, 0, 1'b0, 0, -1);
        idle(16);
        begin
            int n;
            n = 0;
            while (!p_valid && n < 200) begin @(posedge clk); n++; end
            @(negedge clk);
            check("par_valid", {31'h0, p_valid}, 1);
            check("par_data",  {24'h0, p_data},  8'h07);
            check("par_perr",  {31'h0, p_perr},  1);
            check("par_ferr",  {31'h0, p_ferr},  0);
            @(posedge clk); #1; p_ready = 1'b1;
            @(posedge clk); #1; p_ready = 1'b0;
            @(negedge clk);
            check("par_level_after_pop", {29'h0, p_level}, 0);
        end
        p_en  = 1'b0;
        rx_en = 1'b1;
        idle(48);

        // line held low for 12 bit times: one break frame
        exp_q.push_back('{d: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
        for (int i = 0; i < 12 * 16; i++) begin @(posedge clk); #1; rxd = 1'b0; end
        idle(64);
        wait_drain("break_drain");

        // five frames into a 4-deep FIFO with no consumer
        begin
            int ob;
            rx_ready = 1'b0;
            ob = ovr_cnt;
            for (int i = 1; i <= 5; i++) begin
                if (i <= 4) exp_q.push_back('{d: 8'(i), perr: 1'b0, ferr: 1'b0, brk: 1'b0});
                send_frame(8'(i), 0, 1'b0, -1, -1);
                idle(8);
            end
            idle(16);
            @(negedge clk);
            check("ovr_level",  {29'h0, fifo_level}, 4);
            check("ovr_pulses", ovr_cnt - ob, 1);
            @(posedge clk); #1; rx_ready = 1'b1;
            wait_drain("ovr_drain");
        end

        // rx_en dropped during data bit 4: nothing pushed, next frame clean
        rx_ready = 1'b0;
        send_frame(8'h5A, 0, 1'b0, -1, 5);
        idle(16);
        rx_en = 1'b1;
        idle(48);
        @(negedge clk);
        check("drop_level", {29'h0, fifo_level}, 0);
        exp_q.push_back('{d: 8'h9E, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'h9E, 0, 1'b0, -1, -1);
        idle(16);
        @(negedge clk);
        check("after_drop_level", {29'h0, fifo_level}, 1);
        @(posedge clk); #1; rx_ready = 1'b1;
        wait_drain("after_drop_drain");

        idle(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_mc.md
Name: uart_rx_mc

Overview:
Parametrised UART receiver, successor to the fixed 8-bit simulation receiver. Adds runtime baud divisor, 3-sample majority-vote oversampling, configurable data, parity and stop bits, and per-frame error flags. Frames are buffered in a first-word-fall-through FIFO behind a valid/ready interface. Used in verification benches as the DUT-side serial sink; synthesisable apart from the optional print feature.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, 1 or 2
OVERSAMPLE, 16, oversample ticks per bit, even, >= 8
DIV_W, 16, width of baud_div
FIFO_DEPTH, 4, frame FIFO entries, power of two, >= 2

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
rx_en  in  1  receive enable
rxd  in  1  serial input, asynchronous
baud_div  in  DIV_W  clk cycles per oversample tick minus 1
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pops the head entry when rx_valid & rx_ready
rx_data  out  DATA_BITS  head data, LSB = first bit received
rx_perr  out  1  head parity error
rx_ferr  out  1  head framing error (any stop bit sampled 0)
rx_break  out  1  head break: data, parity and all stop bits all 0
rx_overrun  out  1  one-cycle pulse when a frame is dropped on a full FIFO
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Reset (async): rxd synchroniser = 1, FSM = IDLE, FIFO empty, all outputs 0.
- rxd passes through a 2-flop synchroniser (rxd_s). Input registers update only while rx_en = 1.
- Prescaler: baud_div is latched on entering START. The prescaler counts from the latched value down to 0, issuing a tick at 0 and reloading. It is cleared on entering START.
- Sample counter counts 0..OVERSAMPLE-1 per bit. Samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority.
- FSM:
  - IDLE -> START on rx_en & a 1->0 transition of rxd_s.
  - START: if the vote is 1 (false start) -> IDLE with no push. Otherwise -> DATA at bit end.
  - DATA: shift in DATA_BITS bits, LSB first. At the last bit end -> PARITY if PARITY != 0, else STOP.
  - PARITY: perr = the voted bit differs from the expected value (odd: XOR of data and parity bit = 1; even: = 0). -> STOP at bit end.
  - STOP: vote each stop bit; ferr |= (vote == 0). After the majority vote of the final stop bit (not bit end), push the frame and -> IDLE. This allows resynchronisation half a bit early.
- Push timing: the frame is written the cycle after the final vote. rx_valid rises the following cycle. Outputs always present the FIFO head.
- FIFO full on push: the frame is discarded and rx_overrun pulses for 1 cycle. Exception: if a pop occurs in the same cycle, the push is accepted and the level is unchanged.
- Pop and push in the same cycle on a non-full FIFO: level unchanged; head advances correctly, including the empty -> 1 -> pop case.
- rx_en deasserted mid-frame: FSM -> IDLE immediately, frame discarded, FIFO contents and outputs retained.
- Pointers wrap modulo FIFO_DEPTH. fifo_level saturates at FIFO_DEPTH by construction.

Optional Feature:
UART_RX_MC_PRINT_EN
- Defined: a simulation-only negedge-clk process line-buffers each pushed data byte (up to 256 chars).
  - It $writes the buffer on LF (10) or CR (13), or when the buffer is full, then clears it.
  - Frames with ferr or break print "<FERR>" or "<BRK>" instead of the character.
- Not defined: no print logic is compiled; the RTL is fully synthesisable.

Test Plan:
- 8N1, baud_div = 0, OVERSAMPLE = 16 (16 clk/bit), send 0x55 then 0xA3, rx_ready = 1 -> two pops with rx_data 0x55 and 0xA3, all error flags 0.
- PARITY = 2, send 0x07 with parity bit 0 (correct value 1) -> rx_perr = 1, rx_data = 0x07, rx_ferr = 0.
- 1-sample glitch on each data bit (sample OVERSAMPLE/2-1 inverted) of 0x3C -> rx_data = 0x3C. A 4-clk low pulse on idle line -> false start, no push.
- rxd held low for 12 bit times, then high -> one frame with rx_data = 0x00, rx_ferr = 1, rx_break = 1.
- FIFO_DEPTH = 4, rx_ready = 0, send 5 frames 0x01..0x05 -> fifo_level = 4, rx_overrun pulses once on frame 5. Draining pops 0x01..0x04.
- rx_en dropped during bit 4 of a frame -> no push, fifo_level unchanged. The next full frame 0x9E is received correctly.
